// File: rtl/dm_store_buffer.sv
// dm_store_buffer: word store buffer in front of the data memory.
// CPU stores are queued in program order and drained one per cycle into the
// DM write port whenever drain_en is high. Loads look up the buffer
// combinationally and see the youngest pending store to their word.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  input  logic                     drain_en,
  output logic                     dm_memwrite,
  output logic [31:0]              dm_address,
  output logic [31:0]              dm_writedata,
  output logic [31:0]              dm_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; payload fields carry no reset, the valid bits qualify them.
  logic [31:0]       e_addr [DEPTH];
  logic [31:0]       e_data [DEPTH];
  logic [31:0]       e_pc   [DEPTH];
  logic [DEPTH-1:0]  e_valid;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;

  logic              push;
  logic              pop;
  logic [PW-1:0]     idx;

  // Only the word index of the load address takes part in matching.
  logic              unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[31:AW+2], ld_addr[1:0]};

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign st_ready = (cnt != CW'(DEPTH));

  // Reset wins over both push and pop so no DM write escapes a reset cycle.
  assign push = st_valid & st_ready & ~reset;
  assign pop  = drain_en & ~empty & ~reset;

  // DM port always presents the head entry; zero when nothing is pending.
  assign dm_memwrite  = pop;
  assign dm_address   = empty ? '0 : e_addr[head];
  assign dm_writedata = empty ? '0 : e_data[head];
  assign dm_pc        = empty ? '0 : e_pc[head];

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      e_valid <= '0;
    end else begin
      if (push) begin
        e_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload capture at the tail slot on an accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[tail] <= st_addr;
      e_data[tail] <= st_data;
      e_pc[tail]   <= st_pc;
    end
  end

  // Forwarding: walk entries oldest to youngest starting at head so the last
  // match (youngest) overrides earlier ones. A head being popped this cycle is
  // still valid here; a store being pushed this cycle is not yet written.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (e_valid[idx] && (e_addr[idx][AW+1:2] == ld_addr[AW+1:2])) begin
        ld_hit  = 1'b1;
        ld_data = e_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: expected DM writes are queued as
// stores are accepted and compared when the DUT strobes dm_memwrite.
module tb_dm_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        drain_en;
  logic        dm_memwrite;
  logic [31:0] dm_address;
  logic [31:0] dm_writedata;
  logic [31:0] dm_pc;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] tb_mem [int];
  int          tests;
  int          failed;

  dm_store_buffer #(.DEPTH(4), .AW(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_pc        (st_pc),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data),
    .drain_en     (drain_en),
    .dm_memwrite  (dm_memwrite),
    .dm_address   (dm_address),
    .dm_writedata (dm_writedata),
    .dm_pc        (dm_pc),
    .empty        (empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a store request until accepted (bounded), recording the expected DM write.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    int   n;
    logic rdy;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = p;
    n = 0;
    @(negedge clk);
    while (!st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    rdy = st_ready;
    check("push_ready", 32'(rdy), 32'd1);
    @(posedge clk);
    if (rdy) sb.push_back('{a, d, p});
    #1;
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    drain_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!empty && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(empty), 32'd1);
    step();
    drain_en = 1'b0;
  endtask

  // DM-side monitor: every write must match the oldest outstanding store.
  always @(negedge clk) begin
    wr_t w;
    if (!reset && dm_memwrite) begin
      if (sb.size() == 0) begin
        check("dm_unexpected", 32'd1, 32'd0);
      end else begin
        w = sb.pop_front();
        check("dm_address", dm_address, w.a);
        check("dm_writedata", dm_writedata, w.d);
        check("dm_pc", dm_pc, w.p);
      end
      tb_mem[int'(dm_address[11:2])] = dm_writedata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    failed   = 0;
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_pc    = '0;
    ld_addr  = '0;
    drain_en = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_memwrite", 32'(dm_memwrite), 32'd0);
    check("rst_ld_hit", 32'(ld_hit), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_dm_address", dm_address, 32'd0);
    step();

    // 2: single store, then drain
    push_store(32'h10, 32'hAAAA0001, 32'h100);
    @(negedge clk);
    check("t2_count1", 32'(count), 32'd1);
    check("t2_no_write", 32'(dm_memwrite), 32'd0);
    check("t2_head_addr", dm_address, 32'h10);
    step();
    drain_en = 1'b1;
    ld_addr  = 32'h10;
    @(negedge clk);
    check("t2_memwrite", 32'(dm_memwrite), 32'd1);
    check("t2_pop_fwd_hit", 32'(ld_hit), 32'd1);
    check("t2_pop_fwd_data", ld_data, 32'hAAAA0001);
    step();
    drain_en = 1'b0;
    @(negedge clk);
    check("t2_count0", 32'(count), 32'd0);
    check("t2_memwrite_off", 32'(dm_memwrite), 32'd0);
    check("t2_ld_miss", 32'(ld_hit), 32'd0);
    step();

    // 3: fill, hold a 5th store while full, release via drain
    for (int i = 0; i < 4; i++)
      push_store(32'(i * 4), 32'h30000000 + 32'(i), 32'h200 + 32'(i * 4));
    @(negedge clk);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(st_ready), 32'd0);
    step();
    st_valid = 1'b1;
    st_addr  = 32'h40;
    st_data  = 32'h55550005;
    st_pc    = 32'h210;
    @(negedge clk);
    check("t3_hold_ready", 32'(st_ready), 32'd0);
    step();
    @(negedge clk);
    check("t3_hold_count", 32'(count), 32'd4);
    step();
    drain_en = 1'b1;
    @(negedge clk);
    check("t3_ready_not_drain_aware", 32'(st_ready), 32'd0);
    check("t3_drain_write", 32'(dm_memwrite), 32'd1);
    step();
    @(negedge clk);
    check("t3_ready_after_pop", 32'(st_ready), 32'd1);
    check("t3_count3", 32'(count), 32'd3);
    @(posedge clk);
    sb.push_back('{32'h40, 32'h55550005, 32'h210});
    #1 st_valid = 1'b0;
    @(negedge clk);
    check("t3_push_pop_count", 32'(count), 32'd3);
    step();
    drain_all();

    // 4: youngest-match forwarding, no same-cycle forward of a push
    ld_addr  = 32'h20;
    st_valid = 1'b1;
    st_addr  = 32'h20;
    st_data  = 32'd1;
    st_pc    = 32'h300;
    @(negedge clk);
    check("t4_no_same_cycle_fwd", 32'(ld_hit), 32'd0);
    @(posedge clk);
    sb.push_back('{32'h20, 32'd1, 32'h300});
    #1 st_valid = 1'b0;
    @(negedge clk);
    check("t4_fwd_first", ld_data, 32'd1);
    step();
    push_store(32'h20, 32'd2, 32'h304);
    ld_addr = 32'h22;
    @(negedge clk);
    check("t4_fwd_hit", 32'(ld_hit), 32'd1);
    check("t4_fwd_youngest", ld_data, 32'd2);
    step();
    ld_addr = 32'h24;
    @(negedge clk);
    check("t4_other_word_hit", 32'(ld_hit), 32'd0);
    check("t4_other_word_data", ld_data, 32'd0);
    step();
    ld_addr = 32'h10000020;
    @(negedge clk);
    check("t4_upper_bits_ignored", ld_data, 32'd2);
    step();
    drain_all();
    ld_addr = 32'h20;
    @(negedge clk);
    check("t4_after_drain_hit", 32'(ld_hit), 32'd0);
    check("t4_mem_word8", tb_mem.exists(8) ? tb_mem[8] : 32'hDEADBEEF, 32'd2);
    step();

    // 5: steady push+pop across pointer wrap
    push_store(32'h50, 32'h5001, 32'h400);
    push_store(32'h54, 32'h5002, 32'h404);
    drain_en = 1'b1;
    st_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st_addr = 32'h58 + 32'(k * 4);
      st_data = 32'h5003 + 32'(k);
      st_pc   = 32'h408 + 32'(k * 4);
      @(negedge clk);
      check("t5_count_steady", 32'(count), 32'd2);
      check("t5_write_each_cycle", 32'(dm_memwrite), 32'd1);
      @(posedge clk);
      sb.push_back('{st_addr, st_data, st_pc});
      #1;
    end
    st_valid = 1'b0;
    drain_en = 1'b0;
    @(negedge clk);
    check("t5_count_end", 32'(count), 32'd2);
    step();
    drain_all();

    // 6: reset mid-operation discards pending stores
    for (int i = 0; i < 3; i++)
      push_store(32'h60 + 32'(i * 4), 32'h6000 + 32'(i), 32'h500 + 32'(i * 4));
    @(negedge clk);
    check("t6_count3", 32'(count), 32'd3);
    step();
    drain_en = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    check("t6_no_write_in_reset", 32'(dm_memwrite), 32'd0);
    @(posedge clk);
    sb.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_count0", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_memwrite_off", 32'(dm_memwrite), 32'd0);
    repeat (3) step();
    drain_en = 1'b0;
    @(negedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
